// File: rtl/ro_scan_sequencer_pkg.sv
// ============================================================================
// Module   : ro_pkg
// Purpose  : Shared types and helpers for the ring-oscillator scan sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ro_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Width of an oscillator index; a single oscillator still gets one bit.
    function automatic int roIdxW(input int numRo);
        return (numRo > 1) ? $clog2(numRo) : 1;
    endfunction

    function automatic logic [63:0] satInc(input logic [63:0] value,
                                           input logic [63:0] maxValue);
        return (value >= maxValue) ? maxValue : value + 64'd1;
    endfunction

    // Lowest set bit at or above position 'from', or -1 when none exists.
    function automatic int findSetFrom(input logic [15:0] bits, input int from);
        int idx;
        idx = -1;
        for (int i = 15; i >= 0; i--) begin
            if (bits[i] && (i >= from)) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ro_scan_sequencer_edge_counter.sv
// ============================================================================
// Module   : ro_edge_counter
// Purpose  : Synchronises an asynchronous toggle, detects both edges and
//            accumulates them in a saturating counter with clear and enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_edge_counter
    import ro_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam logic [63:0] c_cntMax = 64'((65'd1 << CNT_W) - 65'd1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             w_edge;
    logic             w_atMax;
    logic [CNT_W-1:0] w_countNext;

    assign w_edge      = r_sync2 ^ r_prev;
    assign w_atMax     = (64'(r_count) == c_cntMax);
    assign w_countNext = CNT_W'(satInc(64'(r_count), c_cntMax));

    // The synchroniser keeps running through clear so it is flushed by the
    // time counting is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_sync1 <= tog;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (clr) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (en && w_edge) begin
                r_count <= w_countNext;
                if (w_atMax) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign count = r_count;
    assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: rtl/ro_scan_sequencer.sv
// ============================================================================
// Module   : ro_scan_sequencer
// Purpose  : Scans masked ring oscillators one at a time through a shared
//            edge counter. Optional continuous mode via RO_SCAN_CONT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_scan_sequencer
    import ro_pkg::*;
#(
    parameter int NUM_RO        = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int WINDOW_CYCLES = 1024,
    parameter int CNT_W         = 16
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef RO_SCAN_CONT_EN
    input  logic                        cont,
`endif
    input  logic                        start,
    input  logic [NUM_RO-1:0]           mask,
    input  logic [NUM_RO-1:0]           ro_tog,
    output logic [NUM_RO-1:0]           ro_en,
    output logic                        busy,
    output logic                        sample_valid,
    input  logic                        sample_ready,
    output logic [roIdxW(NUM_RO)-1:0]   sample_id,
    output logic [CNT_W-1:0]            sample_count,
    output logic                        sample_ovf,
    output logic                        done
);

    localparam int c_roIdxW   = roIdxW(NUM_RO);
    localparam int c_timerMax = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int c_timerW   = $clog2(c_timerMax + 1);
    localparam logic [c_timerW-1:0] c_settleLoad = c_timerW'(SETTLE_CYCLES - 1);
    localparam logic [c_timerW-1:0] c_windowLoad = c_timerW'(WINDOW_CYCLES - 1);
    localparam logic [c_timerW-1:0] c_timerOne   = c_timerW'(1);

    state_t                r_state;
    state_t                w_stateNext;
    logic [c_timerW-1:0]   r_timer;
    logic [c_timerW-1:0]   w_timerNext;
    logic [c_roIdxW-1:0]   r_sel;
    logic [c_roIdxW-1:0]   w_selNext;
    logic [NUM_RO-1:0]     r_mask;
    logic [NUM_RO-1:0]     w_maskNext;
    logic                  r_busy;
    logic                  w_busyNext;
    logic                  r_done;
    logic                  w_doneNext;
    logic                  w_cont;
    logic                  w_togSel;
    logic [NUM_RO-1:0]     w_roEn;
    int                    w_startIdx;
    int                    w_nextIdx;
    int                    w_firstIdx;

`ifdef RO_SCAN_CONT_EN
    assign w_cont = cont;
`else
    assign w_cont = 1'b0;
`endif

    assign w_startIdx = findSetFrom(16'(mask), 0);
    assign w_nextIdx  = findSetFrom(16'(r_mask), int'(r_sel) + 1);
    assign w_firstIdx = findSetFrom(16'(r_mask), 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_sel   <= '0;
            r_mask  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_timer <= w_timerNext;
            r_sel   <= w_selNext;
            r_mask  <= w_maskNext;
            r_busy  <= w_busyNext;
            r_done  <= w_doneNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_timerNext = r_timer;
        w_selNext   = r_sel;
        w_maskNext  = r_mask;
        w_busyNext  = r_busy;
        w_doneNext  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && (mask != '0)) begin
                    w_maskNext  = mask;
                    w_selNext   = c_roIdxW'(w_startIdx);
                    w_timerNext = c_settleLoad;
                    w_stateNext = SETTLE;
                    w_busyNext  = 1'b1;
                end
            end
            SETTLE: begin
                if (r_timer == '0) begin
                    w_timerNext = c_windowLoad;
                    w_stateNext = COUNT;
                end else begin
                    w_timerNext = r_timer - c_timerOne;
                end
            end
            COUNT: begin
                if (r_timer == '0) begin
                    w_stateNext = DRAIN;
                end else begin
                    w_timerNext = r_timer - c_timerOne;
                end
            end
            DRAIN: begin
                if (sample_ready) begin
                    if (w_nextIdx >= 0) begin
                        w_selNext   = c_roIdxW'(w_nextIdx);
                        w_timerNext = c_settleLoad;
                        w_stateNext = SETTLE;
                    end else begin
                        // Scan boundary: either wrap to the first oscillator or stop.
                        w_doneNext = 1'b1;
                        if (w_cont) begin
                            w_selNext   = c_roIdxW'(w_firstIdx);
                            w_timerNext = c_settleLoad;
                            w_stateNext = SETTLE;
                        end else begin
                            w_stateNext = IDLE;
                            w_busyNext  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        w_roEn = '0;
        if ((r_state == SETTLE) || (r_state == COUNT)) begin
            w_roEn[r_sel] = 1'b1;
        end
    end

    generate
        if (NUM_RO == 1) begin : g_singleRo
            assign w_togSel = ro_tog[0];
        end else begin : g_multiRo
            assign w_togSel = ro_tog[r_sel];
        end
    endgenerate

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edgeCounter (
        .clk   (clk),
        .rst   (rst),
        .tog   (w_togSel),
        .clr   (r_state == SETTLE),
        .en    (r_state == COUNT),
        .count (sample_count),
        .ovf   (sample_ovf)
    );

    assign ro_en        = w_roEn;
    assign busy         = r_busy;
    assign done         = r_done;
    assign sample_valid = (r_state == DRAIN);
    assign sample_id    = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_ro_scan_sequencer.sv
// ============================================================================
// Module   : tb_ro_scan_sequencer
// Purpose  : Scoreboard bench for ro_scan_sequencer (continuous-mode checks
//            compiled in when RO_SCAN_CONT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ro_scan_sequencer;

    localparam int c_settle = 8;
    localparam int c_window = 1024;

    typedef struct {
        int id;
        int lo;
        int hi;
        int ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  mask;
    logic [3:0]  roTog;
    logic        sampleReady;
    logic [3:0]  roEn;
    logic        busy;
    logic        sampleValid;
    logic [1:0]  sampleId;
    logic [15:0] sampleCount;
    logic        sampleOvf;
    logic        done;

    logic        startSat;
    logic [3:0]  maskSat;
    logic        readySat;
    logic [3:0]  roEnSat;
    logic        busySat;
    logic        validSat;
    logic [1:0]  idSat;
    logic [3:0]  countSat;
    logic        ovfSat;
    logic        doneSat;
`ifdef RO_SCAN_CONT_EN
    logic        cont;
`endif

    exp_t expQ[$];
    int   nChecks   = 0;
    int   nFails    = 0;
    int   doneCount = 0;
    int   prevXfer  = 0;
    int   togPer[4];
    int   togCnt[4];

    always #5 clk = ~clk;

    ro_scan_sequencer #(
        .NUM_RO(4), .SETTLE_CYCLES(c_settle), .WINDOW_CYCLES(c_window), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst(rst),
`ifdef RO_SCAN_CONT_EN
        .cont(cont),
`endif
        .start(start), .mask(mask), .ro_tog(roTog), .ro_en(roEn), .busy(busy),
        .sample_valid(sampleValid), .sample_ready(sampleReady), .sample_id(sampleId),
        .sample_count(sampleCount), .sample_ovf(sampleOvf), .done(done)
    );

    ro_scan_sequencer #(
        .NUM_RO(4), .SETTLE_CYCLES(c_settle), .WINDOW_CYCLES(64), .CNT_W(4)
    ) u_dutSat (
        .clk(clk), .rst(rst),
`ifdef RO_SCAN_CONT_EN
        .cont(1'b0),
`endif
        .start(startSat), .mask(maskSat), .ro_tog(roTog), .ro_en(roEnSat), .busy(busySat),
        .sample_valid(validSat), .sample_ready(readySat), .sample_id(idSat),
        .sample_count(countSat), .sample_ovf(ovfSat), .done(doneSat)
    );

    task automatic check(input string name, input longint act, input longint req);
        nChecks++;
        if (act != req) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic checkRange(input string name, input longint act, input longint lo, input longint hi);
        nChecks++;
        if ((act < lo) || (act > hi)) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic timeoutFail(input string name);
        nChecks++;
        nFails++;
        $display("FAIL %s: timed out, got no event, expected one", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitValid(output int cyc);
        int ok;
        ok  = 0;
        cyc = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            cyc++;
            if (sampleValid) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) timeoutFail("wait_valid");
    endtask

    task automatic waitDone(output int cyc);
        int ok;
        ok  = 0;
        cyc = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            cyc++;
            if (done) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) timeoutFail("wait_done");
    endtask

    task automatic pushExp(input int id, input int lo, input int hi, input int ovf);
        exp_t e;
        e.id  = id;
        e.lo  = lo;
        e.hi  = hi;
        e.ovf = ovf;
        expQ.push_back(e);
    endtask

    // Oscillator models: each toggles once every togPer[i] clocks (0 = static).
    initial begin
        roTog = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            togPer[i] = 0;
            togCnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (togPer[i] != 0) begin
                    togCnt[i]++;
                    if (togCnt[i] >= togPer[i]) begin
                        roTog[i]  = ~roTog[i];
                        togCnt[i] = 0;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks done placement.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prevXfer = 0;
        end else begin
            if (done) begin
                check("done_after_xfer", prevXfer, 1);
                doneCount++;
            end
            if (sampleValid && sampleReady) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected_sample: got id %0d count %0d, expected no sample", sampleId, sampleCount);
                end else begin
                    e = expQ.pop_front();
                    check("sample_id", sampleId, e.id);
                    checkRange("sample_count", sampleCount, e.lo, e.hi);
                    check("sample_ovf", sampleOvf, e.ovf);
                end
            end
            prevXfer = (sampleValid && sampleReady) ? 1 : 0;
        end
    end

    initial begin
        int cyc;
        int bad;
        int base;
        logic [1:0]  holdId;
        logic [15:0] holdCount;
        logic        holdOvf;

        rst = 1'b1; start = 1'b0; mask = 4'b0000; sampleReady = 1'b0;
        startSat = 1'b0; maskSat = 4'b0000; readySat = 1'b1;
`ifdef RO_SCAN_CONT_EN
        cont = 1'b0;
`endif
        repeat (3) tick();
        check("rst_ro_en", roEn, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", sampleValid, 0);
        check("rst_id", sampleId, 0);
        check("rst_count", sampleCount, 0);
        check("rst_ovf", sampleOvf, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Empty mask: request must be ignored.
        bad = 0;
        mask = 4'b0000;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            start = 1'b0;
            if (busy || (roEn != 0) || sampleValid || done) bad = 1;
        end
        check("mask0_ignored", bad, 0);

        // Two-oscillator scan with zero-wait consumer.
        togPer[1] = 8;
        togPer[3] = 4;
        sampleReady = 1'b1;
        pushExp(1, 127, 129, 0);
        pushExp(3, 255, 257, 0);
        base = doneCount;
        mask = 4'b1010;
        start = 1'b1;
        tick();
        start = 1'b0;
        mask = 4'b1111;
        check("start_busy", busy, 1);
        check("start_ro_en", roEn, 4'b0010);
        waitValid(cyc);
        check("valid_latency", cyc, c_settle + c_window);
        waitDone(cyc);
        tick();
        check("scan_done_pulses", doneCount - base, 1);
        check("scan_busy_after", busy, 0);
        check("done_one_cycle", done, 0);
        check("scan_queue_empty", expQ.size(), 0);

        // Backpressure: hold the result for 50 clocks.
        togPer[0] = 8;
        togPer[2] = 0;
        sampleReady = 1'b0;
        pushExp(0, 127, 129, 0);
        pushExp(2, 0, 0, 0);
        mask = 4'b0101;
        start = 1'b1;
        tick();
        start = 1'b0;
        waitValid(cyc);
        holdId = sampleId;
        holdCount = sampleCount;
        holdOvf = sampleOvf;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!sampleValid || (sampleId != holdId) || (sampleCount != holdCount) ||
                (sampleOvf != holdOvf) || (roEn != 0)) bad = 1;
        end
        check("drain_hold_stable", bad, 0);
        sampleReady = 1'b1;
        tick();
        check("next_after_ready_ro_en", roEn, 4'b0100);
        waitDone(cyc);
        check("bp_queue_empty", expQ.size(), 0);

        // Reset in the middle of a count window aborts the scan.
        togPer[2] = 4;
        mask = 4'b0100;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (c_settle + 100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ro_en", roEn, 0);
        check("abort_busy", busy, 0);
        check("abort_valid", sampleValid, 0);
        check("abort_count", sampleCount, 0);
        check("abort_done", done, 0);
        base = doneCount;
        repeat (c_settle + c_window + 20) tick();
        check("abort_no_done", doneCount - base, 0);
        pushExp(2, 255, 257, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_ro_en", roEn, 4'b0100);
        waitDone(cyc);
        check("restart_queue_empty", expQ.size(), 0);

        // Saturation on the narrow-counter instance.
        togPer[0] = 2;
        maskSat = 4'b0001;
        startSat = 1'b1;
        tick();
        startSat = 1'b0;
        bad = 1;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (validSat) begin
                bad = 0;
                break;
            end
        end
        if (bad != 0) timeoutFail("sat_wait_valid");
        check("sat_count", countSat, 15);
        check("sat_ovf", ovfSat, 1);
        check("sat_id", idSat, 0);
        tick();
        check("sat_done", doneSat, 1);

`ifdef RO_SCAN_CONT_EN
        togPer[0] = 8;
        pushExp(0, 127, 129, 0);
        pushExp(0, 127, 129, 0);
        pushExp(0, 127, 129, 0);
        cont = 1'b1;
        mask = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(cyc);
        check("cont_busy_at_done", busy, 1);
        waitDone(cyc);
        check("cont_done_period", cyc, c_settle + c_window + 1);
        cont = 1'b0;
        waitDone(cyc);
        tick();
        check("cont_stop_busy", busy, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sampleValid || (roEn != 0)) bad = 1;
        end
        check("cont_stop_idle", bad, 0);
`endif

        repeat (3) tick();
        check("final_queue_empty", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

`default_nettype wire
